// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer gating the PC load enable of a single-cycle core.
// Raw buttons are synchronised and edge-detected; state and retired count feed debug displays.
module cpu_run_ctrl #(
  parameter int unsigned n           = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             btn_run_i,
  input  logic             btn_halt_i,
  input  logic             btn_step_i,
  input  logic             clr_cnt_i,
  input  logic             bp_en_i,
  input  logic [n-1:0]     bp_addr_i,
  input  logic [n-1:0]     pc_cur_i,
  input  logic [CNT_W-1:0] run_budget_i,
  output logic             pc_load_o,
  output logic [2:0]       state_o,
  output logic             brk_hit_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam logic [2:0] StHalt = 3'd0;
  localparam logic [2:0] StStep = 3'd1;
  localparam logic [2:0] StRun  = 3'd2;
  localparam logic [2:0] StBrk  = 3'd3;

  localparam int unsigned SyncW = 3 * SYNC_STAGES;

  // Each 3-bit slice is one synchroniser stage holding {step, halt, run}.
  logic [SyncW-1:0] sync_q;
  logic [2:0]       prev_q;
  logic [2:0]       btn_p;
  logic             run_p, halt_p, step_p;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] budget_q, budget_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             bp_skip_q, bp_skip_d;
  logic             bp_hit;
  logic             pc_load;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncW-4:0], btn_step_i, btn_halt_i, btn_run_i};
      prev_q <= sync_q[SyncW-1 -: 3];
    end
  end

  assign btn_p  = sync_q[SyncW-1 -: 3] & ~prev_q;
  assign run_p  = btn_p[0];
  assign halt_p = btn_p[1];
  assign step_p = btn_p[2];

  always_comb begin
    bp_hit    = bp_en_i && (pc_cur_i == bp_addr_i) && !bp_skip_q;
    pc_load   = (state_q == StStep) || ((state_q == StRun) && !bp_hit);
    state_d   = state_q;
    budget_d  = budget_q;
    bp_skip_d = bp_skip_q;
    case (state_q)
      StHalt: begin
        if (step_p) begin
          state_d = StStep;
        end else if (run_p) begin
          state_d  = StRun;
          budget_d = run_budget_i;
        end
      end
      StStep: state_d = StHalt;
      StRun: begin
        if (pc_load) begin
          bp_skip_d = 1'b0;
          if (budget_q != '0) budget_d = budget_q - CNT_W'(1);
        end
        // pc_load is implied by !bp_hit in RUN, so the budget test needs no extra term.
        if (bp_hit) begin
          state_d = StBrk;
        end else if (halt_p) begin
          state_d = StHalt;
        end else if (budget_q == CNT_W'(1)) begin
          state_d = StHalt;
        end
        if (state_d != StRun) bp_skip_d = 1'b0;
      end
      StBrk: begin
        if (step_p) begin
          state_d = StStep;
        end else if (run_p) begin
          state_d   = StRun;
          budget_d  = run_budget_i;
          bp_skip_d = 1'b1;
        end
      end
      default: begin
        state_d   = StHalt;
        bp_skip_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    retired_d = retired_q;
    if (clr_cnt_i) begin
      retired_d = '0;
    end else if (pc_load && (retired_q != '1)) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StHalt;
      budget_q  <= '0;
      retired_q <= '0;
      bp_skip_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      budget_q  <= budget_d;
      retired_q <= retired_d;
      bp_skip_q <= bp_skip_d;
    end
  end

  assign pc_load_o = pc_load;
  assign state_o   = state_q;
  assign brk_hit_o = (state_q == StBrk);
  assign retired_o = retired_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a PC model advances on pc_load, and a queue of expected
// executed PCs is checked every time the sequencer asserts pc_load.
module tb_cpu_run_ctrl;

  localparam int unsigned N  = 32;
  localparam int unsigned CW = 4;

  logic          clk_i;
  logic          rst_ni;
  logic          btn_run, btn_halt, btn_step, clr_cnt, bp_en;
  logic [N-1:0]  bp_addr, pc_cur;
  logic [CW-1:0] run_budget;
  logic          pc_load, brk_hit;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [N-1:0]  exp_q[$];
  logic [N-1:0]  exp_pc;

  cpu_run_ctrl #(.n(N), .CNT_W(CW), .SYNC_STAGES(2)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .btn_run_i    (btn_run),
    .btn_halt_i   (btn_halt),
    .btn_step_i   (btn_step),
    .clr_cnt_i    (clr_cnt),
    .bp_en_i      (bp_en),
    .bp_addr_i    (bp_addr),
    .pc_cur_i     (pc_cur),
    .run_budget_i (run_budget),
    .pc_load_o    (pc_load),
    .state_o      (state),
    .brk_hit_o    (brk_hit),
    .retired_o    (retired)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Stand-in for the core's PC register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pc_cur <= '0;
    else if (pc_load) pc_cur <= pc_cur + 32'd4;
  end

  task automatic do_reset();
    btn_run = 0; btn_halt = 0; btn_step = 0; clr_cnt = 0;
    rst_ni = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    btn_run = 0; btn_halt = 0; btn_step = 0; clr_cnt = 0;
    bp_en = 0; bp_addr = '0; run_budget = '0;
    rst_ni = 0;
    #1;
    n_checks++;
    if (state !== 3'd0 || pc_load !== 1'b0 || retired !== '0 || brk_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: state=%0d pc_load=%b retired=%0d brk=%b, need 0/0/0/0",
               state, pc_load, retired, brk_hit);
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
    btn_run = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_i);
      if (c == 4) btn_run = 0;
    end
    n_checks++;
    if (state !== 3'd2 || pc_load !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prerun: state=%0d pc_load=%b, need 2/1", state, pc_load);
    end
    #2 rst_ni = 0;
    #1;
    n_checks++;
    if (state !== 3'd0 || pc_load !== 1'b0 || retired !== '0) begin
      n_fail++;
      $display("FAIL reset_midrun: state=%0d pc_load=%b retired=%0d, need 0/0/0",
               state, pc_load, retired);
    end
    @(negedge clk_i);
    rst_ni = 1;
    repeat (6) @(negedge clk_i);
    n_checks++;
    if (state !== 3'd0 || pc_load !== 1'b0 || retired !== '0) begin
      n_fail++;
      $display("FAIL reset_release: state=%0d pc_load=%b retired=%0d, need 0/0/0",
               state, pc_load, retired);
    end
  endtask

  task automatic test_step();
    do_reset();
    exp_q.delete();
    exp_q.push_back(32'h0);
    btn_step = 1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk_i);
      n_checks++;
      if (pc_load !== (c == 3)) begin
        n_fail++;
        $display("FAIL step_timing: cycle %0d pc_load=%b, need %b", c, pc_load, (c == 3));
      end
      if (pc_load) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL step_sb: load at pc=%0h, none expected", pc_cur);
        end else begin
          exp_pc = exp_q.pop_front();
          if (pc_cur !== exp_pc) begin
            n_fail++;
            $display("FAIL step_sb: pc=%0h, need %0h", pc_cur, exp_pc);
          end
        end
      end
      if (c == 10) btn_step = 0;
    end
    n_checks++;
    if (exp_q.size() != 0 || retired !== 4'd1 || state !== 3'd0) begin
      n_fail++;
      $display("FAIL step_end: left=%0d retired=%0d state=%0d, need 0/1/0",
               exp_q.size(), retired, state);
    end
  endtask

  task automatic test_breakpoint();
    do_reset();
    exp_q.delete();
    bp_en = 1; bp_addr = 32'h10; run_budget = '0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
    btn_run = 1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_i);
      if (pc_load) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL brk_sb: load at pc=%0h, none expected", pc_cur);
        end else begin
          exp_pc = exp_q.pop_front();
          if (pc_cur !== exp_pc) begin
            n_fail++;
            $display("FAIL brk_sb: pc=%0h, need %0h", pc_cur, exp_pc);
          end
        end
      end
      if (c == 4) btn_run = 0;
    end
    n_checks++;
    if (exp_q.size() != 0 || pc_load !== 1'b0 || state !== 3'd3 || brk_hit !== 1'b1 ||
        pc_cur !== 32'h10 || retired !== 4'd4) begin
      n_fail++;
      $display("FAIL brk_stop: left=%0d load=%b state=%0d brk=%b pc=%0h ret=%0d, need 0/0/3/1/10/4",
               exp_q.size(), pc_load, state, brk_hit, pc_cur, retired);
    end
    btn_halt = 1;
    repeat (4) @(negedge clk_i);
    btn_halt = 0;
    repeat (4) @(negedge clk_i);
    n_checks++;
    if (state !== 3'd3 || pc_load !== 1'b0) begin
      n_fail++;
      $display("FAIL brk_halt_ignored: state=%0d pc_load=%b, need 3/0", state, pc_load);
    end
    run_budget = 4'd3;
    exp_q.push_back(32'h10); exp_q.push_back(32'h14); exp_q.push_back(32'h18);
    btn_run = 1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i);
      if (pc_load) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL brk_resume_sb: load at pc=%0h, none expected", pc_cur);
        end else begin
          exp_pc = exp_q.pop_front();
          if (pc_cur !== exp_pc) begin
            n_fail++;
            $display("FAIL brk_resume_sb: pc=%0h, need %0h", pc_cur, exp_pc);
          end
        end
      end
      if (c == 4) btn_run = 0;
    end
    n_checks++;
    if (exp_q.size() != 0 || state !== 3'd0 || retired !== 4'd7 || pc_cur !== 32'h1c) begin
      n_fail++;
      $display("FAIL brk_resume_end: left=%0d state=%0d ret=%0d pc=%0h, need 0/0/7/1c",
               exp_q.size(), state, retired, pc_cur);
    end
    bp_en = 0;
  endtask

  task automatic test_budget();
    do_reset();
    exp_q.delete();
    bp_en = 0; run_budget = 4'd5;
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
    btn_run = 1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk_i);
      if (pc_load) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL budget_sb: load at pc=%0h, none expected", pc_cur);
        end else begin
          exp_pc = exp_q.pop_front();
          if (pc_cur !== exp_pc) begin
            n_fail++;
            $display("FAIL budget_sb: pc=%0h, need %0h", pc_cur, exp_pc);
          end
        end
      end
      if (c == 4) btn_run = 0;
    end
    n_checks++;
    if (exp_q.size() != 0 || state !== 3'd0 || retired !== 4'd5 || pc_cur !== 32'h14) begin
      n_fail++;
      $display("FAIL budget_end: left=%0d state=%0d ret=%0d pc=%0h, need 0/0/5/14",
               exp_q.size(), state, retired, pc_cur);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    exp_q.delete();
    bp_en = 0; run_budget = '0;
    exp_q.push_back(32'h0);
    btn_step = 1; btn_run = 1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i);
      if (c == 3) begin
        n_checks++;
        if (state !== 3'd1) begin
          n_fail++;
          $display("FAIL simul_step_wins: state=%0d, need 1", state);
        end
      end
      if (pc_load) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL simul_sb: load at pc=%0h, none expected", pc_cur);
        end else begin
          exp_pc = exp_q.pop_front();
          if (pc_cur !== exp_pc) begin
            n_fail++;
            $display("FAIL simul_sb: pc=%0h, need %0h", pc_cur, exp_pc);
          end
        end
      end
      if (c == 5) begin btn_step = 0; btn_run = 0; end
    end
    n_checks++;
    if (exp_q.size() != 0 || state !== 3'd0 || retired !== 4'd1) begin
      n_fail++;
      $display("FAIL simul_step_end: left=%0d state=%0d ret=%0d, need 0/0/1",
               exp_q.size(), state, retired);
    end
    // Halt pulse lands in the same cycle the PC reaches the breakpoint.
    bp_en = 1; bp_addr = 32'hc;
    exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    btn_run = 1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_i);
      if (c == 5) begin
        n_checks++;
        if (pc_load !== 1'b0 || pc_cur !== 32'hc) begin
          n_fail++;
          $display("FAIL simul_bp_halt_load: pc_load=%b pc=%0h, need 0/c", pc_load, pc_cur);
        end
      end
      if (pc_load) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL simul_bp_sb: load at pc=%0h, none expected", pc_cur);
        end else begin
          exp_pc = exp_q.pop_front();
          if (pc_cur !== exp_pc) begin
            n_fail++;
            $display("FAIL simul_bp_sb: pc=%0h, need %0h", pc_cur, exp_pc);
          end
        end
      end
      if (c == 3) btn_halt = 1;
      if (c == 8) begin btn_run = 0; btn_halt = 0; end
    end
    n_checks++;
    if (exp_q.size() != 0 || state !== 3'd3 || brk_hit !== 1'b1 || retired !== 4'd3) begin
      n_fail++;
      $display("FAIL simul_bp_end: left=%0d state=%0d brk=%b ret=%0d, need 0/3/1/3",
               exp_q.size(), state, brk_hit, retired);
    end
    bp_en = 0;
  endtask

  task automatic test_counter();
    do_reset();
    exp_q.delete();
    bp_en = 0; run_budget = '0;
    for (int i = 0; i < 20; i++) exp_q.push_back(32'(4 * i));
    btn_run = 1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk_i);
      if (pc_load) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL cnt_sb: load at pc=%0h, none expected", pc_cur);
        end else begin
          exp_pc = exp_q.pop_front();
          if (pc_cur !== exp_pc) begin
            n_fail++;
            $display("FAIL cnt_sb: pc=%0h, need %0h", pc_cur, exp_pc);
          end
        end
      end
      if (c == 4) btn_run = 0;
      if (c == 20) btn_halt = 1;
      if (c == 25) btn_halt = 0;
    end
    n_checks++;
    if (exp_q.size() != 0 || state !== 3'd0 || retired !== 4'd15) begin
      n_fail++;
      $display("FAIL cnt_saturate: left=%0d state=%0d ret=%0d, need 0/0/15",
               exp_q.size(), state, retired);
    end
    exp_q.push_back(32'h50);
    btn_step = 1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_i);
      if (pc_load) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL cnt_clr_sb: load at pc=%0h, none expected", pc_cur);
        end else begin
          exp_pc = exp_q.pop_front();
          if (pc_cur !== exp_pc) begin
            n_fail++;
            $display("FAIL cnt_clr_sb: pc=%0h, need %0h", pc_cur, exp_pc);
          end
        end
      end
      if (c == 4) begin
        n_checks++;
        if (retired !== 4'd0) begin
          n_fail++;
          $display("FAIL cnt_clr_wins: retired=%0d, need 0", retired);
        end
      end
      clr_cnt = (c == 3);
      if (c == 5) btn_step = 0;
    end
    n_checks++;
    if (exp_q.size() != 0 || retired !== 4'd0 || state !== 3'd0) begin
      n_fail++;
      $display("FAIL cnt_clr_end: left=%0d ret=%0d state=%0d, need 0/0/0",
               exp_q.size(), retired, state);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_step();
    test_breakpoint();
    test_budget();
    test_simultaneous();
    test_counter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
